// File: rtl/fir_decimator.sv
// fir_decimator: sums every DEC consecutive accepted FIR samples into one exact
// result and queues results in a two-entry output FIFO. When the FIFO is full
// and nothing pops, the new result is dropped and a sticky overflow flag is set.
module fir_decimator #(
  parameter int BW_IN  = 3,
  parameter int DEC    = 4,
  parameter int BW_OUT = BW_IN + $clog2(DEC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid_i,
  input  logic signed [BW_IN-1:0]  in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [BW_OUT-1:0] out_data_o,
  output logic                     overflow_o
);

  localparam int PW = $clog2(DEC);
  localparam logic [PW-1:0] LAST_PHASE = PW'(DEC - 1);

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_ONE,
    FIFO_FULL
  } fifoState_t;

  logic [PW-1:0]            phase_q, phase_d;
  logic signed [BW_OUT-1:0] acc_q, acc_d;
  logic signed [BW_OUT-1:0] sampleExt;
  logic signed [BW_OUT-1:0] result;
  logic                     push;
  logic                     pop;

  fifoState_t               state_q, state_d;
  logic signed [BW_OUT-1:0] head_q, head_d;
  logic signed [BW_OUT-1:0] tail_q, tail_d;
  logic                     overflow_q, overflow_d;

  // The output width always exceeds the input width, so sign extension is a
  // plain replication of the sample's sign bit.
  assign sampleExt = {{(BW_OUT - BW_IN){in_data_i[BW_IN-1]}}, in_data_i};

  // The completed sum is the running total plus the final sample of the group.
  assign result = acc_q + sampleExt;

  // Phase tracking and accumulation. Phase 0 overwrites the accumulator so
  // no stale value can leak into a new group; the last phase emits and clears.
  always_comb begin
    phase_d = phase_q;
    acc_d   = acc_q;
    push    = 1'b0;
    if (in_valid_i) begin
      if (phase_q == LAST_PHASE) begin
        phase_d = '0;
        acc_d   = '0;
        push    = 1'b1;
      end else begin
        phase_d = phase_q + PW'(1);
        if (phase_q == '0) begin
          acc_d = sampleExt;
        end else begin
          acc_d = acc_q + sampleExt;
        end
      end
    end
  end

  // A pop needs a valid head; out_ready while empty is ignored.
  assign pop = (state_q != FIFO_EMPTY) && out_ready_i;

  // FIFO occupancy and contents. The head always holds the oldest result.
  // A pop moves the tail up; a push in FULL without a pop is dropped.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q;
    unique case (state_q)
      FIFO_EMPTY: begin
        if (push) begin
          head_d  = result;
          state_d = FIFO_ONE;
        end
      end
      FIFO_ONE: begin
        if (push && pop) begin
          head_d = result;
        end else if (push) begin
          tail_d  = result;
          state_d = FIFO_FULL;
        end else if (pop) begin
          state_d = FIFO_EMPTY;
        end
      end
      FIFO_FULL: begin
        if (push && pop) begin
          head_d = tail_q;
          tail_d = result;
        end else if (pop) begin
          head_d  = tail_q;
          state_d = FIFO_ONE;
        end else if (push) begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = FIFO_EMPTY;
      end
    endcase
  end

  // All state registers, with synchronous reset taking priority over
  // any accept, push or pop on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      acc_q      <= '0;
      state_q    <= FIFO_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
    end
  end

  // The head is masked to zero while empty so stale entries never show.
  assign out_valid_o = (state_q != FIFO_EMPTY);
  assign out_data_o  = out_valid_o ? head_q : '0;
  assign overflow_o  = overflow_q;

endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 Parameter: BW_IN, default 3, width of the signed FIR output sample consumed.
REQ-002 Parameter: DEC, default 4, decimation factor; SHALL be a power of two in 2..16.
REQ-003 Parameter: BW_OUT, default BW_IN+log2(DEC), width of the signed decimated result.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream FIR sample valid this cycle; there is no upstream backpressure.
REQ-007 in_data  input  BW_IN  signed FIR output sample (two's complement).
REQ-008 out_valid  output  1  decimated result available at out_data.
REQ-009 out_ready  input  1  downstream accepts the result when out_valid=1.
REQ-010 out_data  output  BW_OUT  signed decimated sum, head of output FIFO.
REQ-011 overflow  output  1  sticky flag; a result was dropped because the FIFO was full.

Function
REQ-012 A sample SHALL be accepted on every rising edge with in_valid=1; in_valid=0 SHALL leave all state unchanged except FIFO pops.
REQ-013 A phase counter (0..DEC-1) SHALL increment on each accepted sample and wrap from DEC-1 to 0.
REQ-014 The accumulator SHALL add the sign-extended in_data on each accepted sample at phase 0..DEC-2; the phase-0 add SHALL overwrite, not add to, any prior value.
REQ-015 On acceptance at phase DEC-1, result = accumulator + sign-extended in_data SHALL be pushed to the output FIFO, and the accumulator SHALL clear to 0 on the same edge.
REQ-016 Arithmetic SHALL be exact: BW_OUT bits hold any sum of DEC BW_IN-bit samples; no saturation or rounding.
REQ-017 The output FIFO SHALL hold 2 entries, strictly in order; occupancy state machine EMPTY -> ONE -> FULL.
REQ-018 Transitions: push only: EMPTY->ONE, ONE->FULL; pop only: FULL->ONE, ONE->EMPTY; push+pop: state unchanged.
REQ-019 Pop SHALL occur on an edge with out_valid=1 and out_ready=1; out_valid SHALL equal (state != EMPTY).
REQ-020 out_data SHALL show the oldest entry; SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Latency: a result SHALL appear at out_data with out_valid=1 in the cycle following the accepting edge (when FIFO was EMPTY).
REQ-022 Push in FULL with simultaneous pop SHALL be accepted (no drop); the new result becomes the tail.
REQ-023 Push in FULL without pop SHALL drop the new result, leave FIFO contents unchanged, and set overflow=1.
REQ-024 overflow SHALL remain 1 until reset; accumulation SHALL continue normally after a drop.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 out_data SHALL read 0 when the FIFO is EMPTY.

Reset
REQ-027 On reset=1 at a rising edge: accumulator=0, phase=0, FIFO EMPTY, out_valid=0, out_data=0, overflow=0.
REQ-028 Reset SHALL take priority over any simultaneous accept, push or pop; a partial sum in progress SHALL be discarded.
REQ-029 The first sample accepted after reset deasserts SHALL be phase 0.

Verification (DEC=4, BW_IN=3, BW_OUT=5)
REQ-030 in_valid=1, samples 1,2,3,1, out_ready=1 -> out_valid=1, out_data=7 one cycle after 4th edge, then out_valid=0.
REQ-031 Samples -4,-4,-4,-4 then 3,3,3,3, out_ready=1 -> out_data -16 (5'b10000) then 12; overflow=0.
REQ-032 out_ready=0, 12 samples of 1 -> FIFO holds 4,4; third result dropped, overflow=1; then out_ready=1 -> pops 4, 4, out_valid=0, overflow stays 1.
REQ-033 Samples 2,_,2,_,_,2,2 (_ = in_valid=0) -> single result 8, emitted only after the 4th valid sample.
REQ-034 Two samples of 3, then reset one cycle, then 1,1,1,1 -> result 4 (partial 6 discarded); out_valid=0 during and right after reset.
REQ-035 FIFO FULL, out_ready=1 on the same edge as a new push -> no drop, overflow=0, outputs appear in order of production.
